// File: rtl/conv_word_fifo.sv
// conv_word_fifo: buffers packed convolution words and reports space/full status back to the packer.
// A write is taken once per rising edge of wr_valid. Reads have one cycle of registered latency.
module conv_word_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic [1:0]        fifo_status,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [ADDR_W:0] full_cnt = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              wr_valid_d, full, empty, wr_stb, wr_acc, rd_acc;

    assign full      = count == full_cnt;
    assign empty     = count == '0;
    assign wr_stb    = wr_valid & ~wr_valid_d & wr_data[DATA_W-1];
    assign wr_acc    = wr_stb & ~full;
    assign rd_acc    = rd_en & ~empty;
    assign count_nxt = count + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            fifo_status <= 2'b00;
            wr_valid_d  <= 1'b0;
        end else begin
            wr_valid_d  <= wr_valid;
            count       <= count_nxt;
            // Registered from the next count so the packer sees full before its next word.
            fifo_status <= (count_nxt == full_cnt) ? 2'b01 : 2'b10;
            rd_valid    <= rd_acc;
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            if (wr_stb & full) overflow <= 1'b1;
            if (rd_en & empty) underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_acc) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_conv_word_fifo.sv
// tb_conv_word_fifo: table-driven vectors plus hand-written multi-cycle sequences for conv_word_fifo.
module tb_conv_word_fifo;
    logic        clk = 1'b0;
    logic        reset, wr_valid, rd_en;
    logic [63:0] wr_data, rd_data;
    logic [1:0]  fifo_status;
    logic        rd_valid, overflow, underflow;
    logic [4:0]  count;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] q[$];
    logic [63:0] a_word = 64'h8000_0000_0000_0ABC;

    always #5 clk = ~clk;

    conv_word_fifo dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .fifo_status(fifo_status), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    typedef struct {
        logic        rst;
        logic        wv;
        logic [63:0] wd;
        logic        re;
        logic [4:0]  c;
        logic [1:0]  st;
        logic        rv;
        logic [63:0] rd;
        logic        ov;
        logic        un;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic wv, input logic [63:0] wd, input logic re);
        reset = r; wr_valid = wv; wr_data = wd; rd_en = re;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_pulse(input logic [63:0] w);
        step(1, 1, w, 0);
        step(1, 0, w, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_status", 64'(fifo_status), 0);
        chk("rst_rd_valid", 64'(rd_valid), 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_overflow", 64'(overflow), 0);
        chk("rst_underflow", 64'(underflow), 0);
        step(1, 0, 0, 0);
        chk("rel_status", 64'(fifo_status), 64'(2'b10));
        q.delete();
    endtask

    initial begin
        reset = 0; wr_valid = 0; wr_data = 0; rd_en = 0;
        tbl[0]  = '{0, 0, 64'h0, 0, 0, 2'b00, 0, 64'h0, 0, 0};
        tbl[1]  = '{1, 0, 64'h0, 0, 0, 2'b10, 0, 64'h0, 0, 0};
        tbl[2]  = '{1, 1, a_word, 0, 1, 2'b10, 0, 64'h0, 0, 0};
        tbl[3]  = '{1, 1, a_word, 0, 1, 2'b10, 0, 64'h0, 0, 0};
        tbl[4]  = '{1, 1, a_word, 0, 1, 2'b10, 0, 64'h0, 0, 0};
        tbl[5]  = '{1, 1, a_word, 0, 1, 2'b10, 0, 64'h0, 0, 0};
        tbl[6]  = '{1, 1, a_word, 0, 1, 2'b10, 0, 64'h0, 0, 0};
        tbl[7]  = '{1, 0, 64'h0, 1, 0, 2'b10, 1, a_word, 0, 0};
        tbl[8]  = '{1, 0, 64'h0, 0, 0, 2'b10, 0, a_word, 0, 0};
        tbl[9]  = '{1, 1, 64'h0000_0000_0000_1234, 0, 0, 2'b10, 0, a_word, 0, 0};
        tbl[10] = '{1, 0, 64'h0, 0, 0, 2'b10, 0, a_word, 0, 0};
        tbl[11] = '{1, 0, 64'h0, 1, 0, 2'b10, 0, a_word, 0, 1};
        tbl[12] = '{0, 0, 64'h0, 0, 0, 2'b00, 0, 64'h0, 0, 0};
        tbl[13] = '{1, 0, 64'h0, 0, 0, 2'b10, 0, 64'h0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].wv, tbl[i].wd, tbl[i].re);
            chk($sformatf("v%0d_count", i), 64'(count), 64'(tbl[i].c));
            chk($sformatf("v%0d_status", i), 64'(fifo_status), 64'(tbl[i].st));
            chk($sformatf("v%0d_rd_valid", i), 64'(rd_valid), 64'(tbl[i].rv));
            chk($sformatf("v%0d_rd_data", i), rd_data, tbl[i].rd);
            chk($sformatf("v%0d_overflow", i), 64'(overflow), 64'(tbl[i].ov));
            chk($sformatf("v%0d_underflow", i), 64'(underflow), 64'(tbl[i].un));
        end

        // Fill to full, overflow on 17th, drain in order.
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 64'h8000_0000_0000_0000 + 64'(i), 0);
            chk("fill_status", 64'(fifo_status), (i == 15) ? 64'(2'b01) : 64'(2'b10));
            step(1, 0, 0, 0);
        end
        chk("fill_count", 64'(count), 16);
        wr_pulse(64'h8000_0000_0000_00FF);
        chk("ovf_flag", 64'(overflow), 1);
        chk("ovf_count", 64'(count), 16);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 1);
            chk("drain_valid", 64'(rd_valid), 1);
            chk("drain_data", rd_data, 64'h8000_0000_0000_0000 + 64'(i));
        end
        chk("drain_count", 64'(count), 0);
        chk("drain_status", 64'(fifo_status), 64'(2'b10));
        step(1, 0, 0, 0);
        chk("drain_valid_off", 64'(rd_valid), 0);

        // Write and read together while full.
        do_reset();
        for (int i = 0; i < 16; i++) wr_pulse(64'h8000_0000_0000_0100 + 64'(i));
        chk("full_status", 64'(fifo_status), 64'(2'b01));
        step(1, 1, 64'h8000_0000_0000_0777, 1);
        chk("fullrw_data", rd_data, 64'h8000_0000_0000_0100);
        chk("fullrw_valid", 64'(rd_valid), 1);
        chk("fullrw_count", 64'(count), 15);
        chk("fullrw_ovf", 64'(overflow), 1);
        chk("fullrw_status", 64'(fifo_status), 64'(2'b10));
        step(1, 0, 0, 0);

        // Write and read together while empty.
        do_reset();
        step(1, 1, 64'h8123_4567_89AB_CDEF, 1);
        chk("emptyrw_valid", 64'(rd_valid), 0);
        chk("emptyrw_unf", 64'(underflow), 1);
        chk("emptyrw_count", 64'(count), 1);
        step(1, 0, 0, 1);
        chk("emptyrw_rd_valid", 64'(rd_valid), 1);
        chk("emptyrw_rd_data", rd_data, 64'h8123_4567_89AB_CDEF);

        // Pointer wrap with interleaved bursts, then mid-stream reset.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 6; i++) begin
                q.push_back(64'h8000_0000_0000_1000 + 64'(b * 6 + i));
                wr_pulse(q[$]);
            end
            for (int i = 0; i < 4; i++) begin
                step(1, 0, 0, 1);
                chk("wrap_data", rd_data, q.pop_front());
            end
        end
        chk("wrap_count", 64'(count), 8);
        q.push_back(64'h8000_0000_0000_2000);
        step(1, 1, q[$], 1);
        chk("both_data", rd_data, q.pop_front());
        chk("both_count", 64'(count), 8);
        step(1, 0, 0, 0);
        while (q.size() > 0) begin
            step(1, 0, 0, 1);
            chk("wrap_tail", rd_data, q.pop_front());
        end
        step(1, 0, 0, 1);
        chk("wrap_unf", 64'(underflow), 1);
        for (int i = 0; i < 3; i++) wr_pulse(64'h8000_0000_0000_3000 + 64'(i));
        chk("pre_rst_count", 64'(count), 3);
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_word_fifo.md
Name: conv_word_fifo

Overview:
- Downstream stage of the convolution output packer. It accepts the packed 64-bit words {valid, 3'b000, elem2, elem1, elem0}, each element 20 bits wide, and buffers them in a synchronous FIFO.
- It drives the 2-bit fifo_status back to the packer for flow control.
- The read side feeds the next layer or the memory writer, with 1-cycle registered read latency.

Parameters:
- DEPTH, 16, number of 64-bit entries; must be a power of two.
- ADDR_W, 4, log2(DEPTH).
- DATA_W, 64, word width; fixed at 64 for the packed format.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- wr_valid  input  1  packer word-valid level; may stay high across many cycles.
- wr_data  input  64  packed word; bit 63 is the word-valid marker, bits 62:60 are zero, bits 59:0 are three 20-bit elements.
- fifo_status  output  2  2'b10 = space available (packer may sample); 2'b01 = full; 2'b00 = in reset.
- rd_en  input  1  read request from the consumer.
- rd_data  output  64  word popped from the FIFO, registered.
- rd_valid  output  1  1-cycle pulse, rd_data valid.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset is synchronous: reset sampled low at a rising edge clears state at that edge. Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0
  - rd_data = 0, rd_valid = 0
  - overflow = 0, underflow = 0
  - fifo_status = 2'b00
  - wr_valid_d = 0 (the registered copy of wr_valid)
  - Storage array contents are not reset.
- Write strobe: wr_stb = wr_valid & ~wr_valid_d & wr_data[63].
  - A write is taken on the rising edge of wr_valid only; a level held high writes exactly once.
  - If bit 63 = 0 on the rising edge, the word is dropped silently. It does not set overflow and count is unchanged.
- Write accept: wr_acc = wr_stb & (count != DEPTH).
  - The word is stored at mem[wr_ptr], and wr_ptr = wr_ptr+1 modulo DEPTH (natural wrap).
  - If wr_stb & full, the word is dropped and overflow is set. Overflow clears only on reset.
- Read accept: rd_acc = rd_en & (count != 0).
  - rd_data <= mem[rd_ptr], rd_ptr increments modulo DEPTH, and rd_valid = 1 for the next cycle only.
  - If rd_en & empty, rd_data holds its value, rd_valid = 0, and underflow is set (sticky).
- Full and empty are evaluated on the pre-edge count in the same cycle:
  - Simultaneous write and read when full: the read is accepted, the write is rejected, overflow is set, and count becomes DEPTH-1.
  - Simultaneous write and read when empty: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
  - Simultaneous write and read, both accepted: count unchanged, both pointers advance.
  - Write only: count + 1. Read only: count - 1.
- fifo_status is registered and computed from the next count:
  - 2'b01 when next count == DEPTH, else 2'b10.
  - The first cycle after reset is released shows 2'b10.
  - Full is reported in the same cycle count reaches DEPTH, so the packer sees 2'b01 before its next word.
- Latency:
  - Write to readable: 1 cycle. A word accepted at edge N may be requested by rd_en in cycle N+1, and rd_data is valid after edge N+2.
  - rd_en to rd_data: 1 cycle.
- Reset asserted mid-operation discards all contents immediately at the next edge. Sticky flags clear and fifo_status = 2'b00 while reset is held.
- Data passes through unmodified; bit 63 remains 1 in stored words.

Test Plan:
- Reset, then hold wr_valid = 1 with wr_data = 64'h8000_0000_0000_0ABC for 5 cycles -> count = 1, one entry stored, fifo_status = 2'b10; rd_en -> next cycle rd_data = 64'h8000_0000_0000_0ABC, rd_valid = 1 for exactly one cycle, count = 0.
- Pulse wr_valid 16 times with words 64'h8000_0000_0000_0000+i -> count = 16, fifo_status = 2'b01 on the cycle after the 16th write; a 17th pulse -> dropped, overflow = 1, count stays 16; 16 reads return i = 0..15 in order.
- Rising edge of wr_valid with wr_data[63] = 0 (64'h0000_0000_0000_1234) -> count stays 0, overflow stays 0.
- Fill to 16, then write pulse and rd_en in the same cycle -> read returns the oldest word, count = 15, overflow = 1, fifo_status returns to 2'b10.
- With the FIFO empty, rd_en and a write pulse in the same cycle -> rd_valid = 0, underflow = 1, count = 1; next rd_en returns the written word.
- Write 24 words in bursts interleaved with reads so the pointers wrap past 15 -> data order preserved; assert reset low mid-stream -> count = 0, fifo_status = 2'b00, flags = 0 at the next edge, 2'b10 after release.
